// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute-stage ALU.
//   - opcode encodings (OP_ADD .. OP_MUL)
//   - forwarding select encodings (FWD_RF, FWD_MEM, FWD_WB); 2'b11 also reads the register file
//   - FSM state encoding for the sequencing control (ST_IDLE, ST_MUL)
package ex_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, one partial-product step per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all multiplier state)
//   start         load mcand=a, mplier=b, acc=0, cnt=0 and begin iterating
//   abort         stop iterating; no done pulse follows
//   a, b          unsigned operands, sampled on start
//   done          high in the cycle whose step is the last (cnt == WIDTH-1)
//   product       low WIDTH bits of a*b, valid while done is high
module ex_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic [WIDTH-1:0] acc_nxt;

  // The final step's sum is handed out combinationally so the result can be
  // registered by the parent on the same edge that completes the last step.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    done    = active && (cnt == CNT_W'(WIDTH - 1));
    product = acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(WIDTH - 1)) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_alu_seq.sv
// ex_alu_seq: registered execute-stage ALU with operand forwarding, a valid/ready
// handshake and an optional iterative multiplier that blocks issue while running.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   issue handshake; in_ready depends only on state and rst
//   alu_ctrl            opcode (see ex_pkg)
//   alu_src             1 selects sign-extended imm as operand B
//   fwd_a, fwd_b        operand sources: register file / MEM result / WB result
//   imm, rd1, rd2       immediate and register-file operands
//   res_mem, res_wb     forwarded results
//   flush               drops the presented op and aborts a running multiply
//   out_valid           one-cycle pulse qualifying alu_out/zero
//   alu_out, zero       registered result and its zero flag (held otherwise)
//   busy                multiplier running
module ex_alu_seq import ex_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 12,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic             alu_src,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] res_mem,
  input  logic [WIDTH-1:0] res_wb,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             busy
);

  localparam int   SH_W        = $clog2(WIDTH);
  localparam logic MUL_PRESENT = (MUL_EN != 0);

  function automatic logic signed [WIDTH-1:0] sext_imm(input logic [IMM_W-1:0] v);
    logic signed [IMM_W-1:0] s;
    s = v;
    return WIDTH'(s);
  endfunction

  state_t state;
  state_t state_nxt;

  logic                    accept;
  logic                    is_mul;
  logic                    mul_start;
  logic                    mul_abort;
  logic                    mul_done;
  logic [WIDTH-1:0]        mul_prod;
  logic signed [WIDTH-1:0] op_a_p0;
  logic signed [WIDTH-1:0] fwd_b_p0;
  logic signed [WIDTH-1:0] op_b_p0;
  logic [SH_W-1:0]         shamt_p0;
  logic [WIDTH-1:0]        res_p0;

  // ---- stage 0: operand selection and single-cycle result ----
  always_comb begin
    case (fwd_a)
      FWD_MEM: op_a_p0 = res_mem;
      FWD_WB:  op_a_p0 = res_wb;
      default: op_a_p0 = rd1;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_b_p0 = res_mem;
      FWD_WB:  fwd_b_p0 = res_wb;
      default: fwd_b_p0 = rd2;
    endcase
    op_b_p0  = alu_src ? sext_imm(imm) : fwd_b_p0;
    shamt_p0 = op_b_p0[SH_W-1:0];
  end

  // MUL (and every unused code) yields 0 here; with the multiplier present
  // the MUL result instead comes from ex_mul_iter.
  always_comb begin
    res_p0 = '0;
    case (alu_ctrl)
      OP_ADD:  res_p0 = op_a_p0 + op_b_p0;
      OP_SUB:  res_p0 = op_a_p0 - op_b_p0;
      OP_XOR:  res_p0 = op_a_p0 ^ op_b_p0;
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (op_a_p0 < op_b_p0)};
      OP_SLL:  res_p0 = $unsigned(op_a_p0) << shamt_p0;
      OP_SRL:  res_p0 = $unsigned(op_a_p0) >> shamt_p0;
      OP_OR:   res_p0 = op_a_p0 | op_b_p0;
      OP_AND:  res_p0 = op_a_p0 & op_b_p0;
      default: res_p0 = '0;
    endcase
  end

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start)            state_nxt = ST_MUL;
      ST_MUL:  if (flush || mul_done)    state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    busy      = (state == ST_MUL);
    accept    = in_valid && in_ready && !flush;
    is_mul    = (alu_ctrl == OP_MUL);
    mul_start = accept && is_mul && MUL_PRESENT;
    mul_abort = busy && flush;
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      ex_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       ($unsigned(op_a_p0)),
        .b       ($unsigned(op_b_p0)),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // ---- stage 1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !mul_start) begin
        out_valid <= 1'b1;
        alu_out   <= res_p0;
        zero      <= (res_p0 == '0);
      end else if (busy && mul_done && !flush) begin
        out_valid <= 1'b1;
        alu_out   <= mul_prod;
        zero      <= (mul_prod == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_seq.sv
module tb_ex_alu_seq;

  localparam int WIDTH = 32;
  localparam int IMM_W = 12;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic             alu_src;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] res_mem;
  logic [WIDTH-1:0] res_wb;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             busy;

  ex_alu_seq #(.WIDTH(WIDTH), .IMM_W(IMM_W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_src   (alu_src),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .imm       (imm),
    .rd1       (rd1),
    .rd2       (rd2),
    .res_mem   (res_mem),
    .res_wb    (res_wb),
    .flush     (flush),
    .out_valid (out_valid),
    .alu_out   (alu_out),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_out;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        src;
    logic [11:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] mem;
    logic [31:0] wb;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: plain wide arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned wa;
    longint unsigned wb2;
    int sa;
    int sb;
    wa = a;
    wb2 = b;
    sa = a;
    sb = b;
    case (op)
      4'd0: return 32'(wa + wb2);
      4'd1: return 32'(wa - wb2);
      4'd2: return a ^ b;
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return a << (b % 32);
      4'd5: return a >> (b % 32);
      4'd6: return a | b;
      4'd7: return a & b;
      4'd8: return 32'(wa * wb2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_sel(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return rf;
  endfunction

  function automatic logic [31:0] ref_sext(input logic [11:0] v);
    int x;
    x = int'(v);
    if (x >= 2048) x = x - 4096;
    return 32'(x);
  endfunction

  task automatic drive(input vec_t v);
    alu_ctrl = v.op;
    fwd_a    = v.fa;
    fwd_b    = v.fb;
    alu_src  = v.src;
    imm      = v.imm;
    rd1      = v.rd1;
    rd2      = v.rd2;
    res_mem  = v.mem;
    res_wb   = v.wb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MUL via register-file operands, with an ADD (7+8) waiting behind it.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp = ref_alu(4'd8, a, b);
    drive('{4'd8, 2'd0, 2'd0, 1'b0, 12'd0, a, b, 32'd0, 32'd0, 32'd0, 1'b0});
    in_valid = 1'b1;
    check("mul_ready_before", in_ready, 1);
    step();
    drive('{4'd0, 2'd0, 2'd0, 1'b0, 12'd0, 32'd7, 32'd8, 32'd0, 32'd0, 32'd0, 1'b0});
    for (int i = 1; i <= WIDTH; i++) begin
      check("mul_busy", busy, 1);
      check("mul_ready_low", in_ready, 0);
      check("mul_no_valid", out_valid, 0);
      check("mul_out_hold", alu_out, last_out);
      step();
    end
    check("mul_valid", out_valid, 1);
    check("mul_result", alu_out, exp);
    check("mul_zero", zero, (exp == 32'd0));
    check("mul_ready_done", in_ready, 1);
    check("mul_busy_done", busy, 0);
    step();
    in_valid = 1'b0;
    check("post_mul_valid", out_valid, 1);
    check("post_mul_add", alu_out, 32'd15);
    last_out = 32'd15;
    step();
    check("post_mul_pulse", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;

    vecs[0]  = '{4'h0, 2'b01, 2'b00, 1'b1, 12'hFFF, 32'd5, 32'd0, 32'h10, 32'h0, 32'h0000000F, 1'b0};
    vecs[1]  = '{4'h0, 2'b10, 2'b00, 1'b1, 12'hFFF, 32'd5, 32'd0, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{4'h1, 2'b00, 2'b00, 1'b0, 12'h0, 32'h80000000, 32'd1, 32'h0, 32'h0, 32'h7FFFFFFF, 1'b0};
    vecs[3]  = '{4'h3, 2'b00, 2'b00, 1'b0, 12'h0, 32'h80000000, 32'd1, 32'h0, 32'h0, 32'h1, 1'b0};
    vecs[4]  = '{4'h5, 2'b00, 2'b00, 1'b0, 12'h0, 32'h80000000, 32'd1, 32'h0, 32'h0, 32'h40000000, 1'b0};
    vecs[5]  = '{4'h4, 2'b00, 2'b00, 1'b0, 12'h0, 32'h80000000, 32'd1, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{4'h2, 2'b00, 2'b00, 1'b0, 12'h0, 32'h80000000, 32'd1, 32'h0, 32'h0, 32'h80000001, 1'b0};
    vecs[7]  = '{4'hF, 2'b00, 2'b00, 1'b0, 12'h0, 32'h80000000, 32'd1, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{4'h6, 2'b11, 2'b01, 1'b0, 12'h0, 32'hF0, 32'h0, 32'h0F, 32'h0, 32'hFF, 1'b0};
    vecs[9]  = '{4'h7, 2'b00, 2'b10, 1'b0, 12'h0, 32'hF0, 32'h0, 32'h0, 32'h3C, 32'h30, 1'b0};
    vecs[10] = '{4'h3, 2'b00, 2'b00, 1'b1, 12'h800, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{4'h4, 2'b00, 2'b00, 1'b0, 12'h0, 32'd3, 32'h21, 32'h0, 32'h0, 32'd6, 1'b0};
    vecs[12] = '{4'h1, 2'b00, 2'b00, 1'b0, 12'h0, 32'd0, 32'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0};

    drive('{4'h0, 2'd0, 2'd0, 1'b0, 12'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0});
    flush    = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b1;
    last_out = 32'd0;

    // Reset held 3 cycles with an op presented.
    #1;
    check("rst_ready", in_ready, 0);
    repeat (3) begin
      step();
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_out", alu_out, 0);
      check("rst_zero", zero, 0);
      check("rst_busy", busy, 0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Directed table, issued back to back.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_out", i), alu_out, vecs[i].exp_out);
      check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
    end
    in_valid = 1'b0;
    last_out = vecs[12].exp_out;
    step();
    check("idle_valid", out_valid, 0);
    check("idle_hold", alu_out, last_out);

    // Randomized single-cycle ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      rv.op  = 4'($urandom_range(0, 15));
      if (rv.op == 4'd8) rv.op = 4'd9;
      rv.fa  = 2'($urandom_range(0, 3));
      rv.fb  = 2'($urandom_range(0, 3));
      rv.src = 1'($urandom_range(0, 1));
      rv.imm = 12'($urandom);
      rv.rd1 = $urandom;
      rv.rd2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rv.mem = $urandom;
      rv.wb  = $urandom;
      a = ref_sel(rv.fa, rv.rd1, rv.mem, rv.wb);
      b = rv.src ? ref_sext(rv.imm) : ref_sel(rv.fb, rv.rd2, rv.mem, rv.wb);
      exp = ref_alu(rv.op, a, b);
      drive(rv);
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        step();
        check("rnd_idle_valid", out_valid, 0);
        check("rnd_idle_hold", alu_out, last_out);
      end else begin
        in_valid = 1'b1;
        step();
        check("rnd_valid", out_valid, 1);
        check("rnd_out", alu_out, exp);
        check("rnd_zero", zero, (exp == 32'd0));
        last_out = exp;
      end
    end
    in_valid = 1'b0;
    step();

    // Multiplies, including the directed case and edge operands.
    run_mul(32'h0000FFFF, 32'h00010001);
    run_mul(32'h12345678, 32'h0);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mul($urandom, $urandom);
    run_mul($urandom, $urandom);

    // Flush during a multiply.
    drive('{4'd8, 2'd0, 2'd0, 1'b0, 12'd0, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0});
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      check("fl_busy", busy, 1);
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_busy_clr", busy, 0);
    check("fl_ready", in_ready, 1);
    check("fl_hold", alu_out, last_out);
    for (int i = 0; i < 30; i++) begin
      step();
      check("fl_no_late_valid", out_valid, 0);
    end

    // Flush coincident with a valid ADD.
    drive('{4'd0, 2'd0, 2'd0, 1'b0, 12'd0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0});
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("fl_add_valid", out_valid, 0);
    check("fl_add_hold", alu_out, last_out);
    step();
    check("fl_add_valid2", out_valid, 0);

    // Reset in the middle of a multiply.
    drive('{4'd8, 2'd0, 2'd0, 1'b0, 12'd0, 32'h0000FFFF, 32'h00010001, 32'd0, 32'd0, 32'd0, 1'b0});
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("rm_busy", busy, 1);
    rst = 1'b1;
    step();
    check("rm_out", alu_out, 0);
    check("rm_zero", zero, 0);
    check("rm_valid", out_valid, 0);
    check("rm_busy_clr", busy, 0);
    check("rm_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rm_ready", in_ready, 1);
    last_out = 32'd0;
    for (int i = 0; i < 35; i++) begin
      step();
      check("rm_no_valid", out_valid, 0);
    end
    drive('{4'd7, 2'd0, 2'd0, 1'b0, 12'd0, 32'hF0, 32'h3C, 32'd0, 32'd0, 32'd0, 1'b0});
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rm_and_valid", out_valid, 1);
    check("rm_and_out", alu_out, 32'h30);
    check("rm_and_zero", zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
